// File: rtl/regfile_pkg.sv
// Shared register-file types for writeback sources and the write arbiter.
package regfile_pkg;
  localparam int RF_AW = 5;
  localparam int RF_DW = 32;
  localparam logic [RF_AW-1:0] RF_ZERO_REG = 5'd0;

  typedef logic [RF_AW-1:0] rf_addr_t;
  typedef logic [RF_DW-1:0] rf_data_t;

  typedef struct packed {
    logic     valid;
    rf_addr_t addr;
    rf_data_t data;
  } wb_req_t;
endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Writeback request bus: NREQ requesters with valid/ready handshakes.
interface regfile_write_arbiter_if #(
  parameter int NREQ = 2,
  parameter int AW   = 5,
  parameter int DW   = 32
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;

  modport master (
    output req_valid,
    output req_addr,
    output req_data,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    input  req_data,
    output req_ready
  );
endinterface

// File: rtl/regfile_write_arbiter_rr_priority_pick.sv
// Round-robin pick: first set req bit at or after ptr, wrapping mod N.
module rr_priority_pick #(
  parameter  int N  = 2,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);
  int j;

  // Scan farthest first so the closest hit to ptr wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % N;
      if (req[j]) begin
        any      = 1'b1;
        idx      = IW'(j);
        grant    = '0;
        grant[j] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register file write port among NREQ writeback sources.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter  int NREQ = 2,
  parameter  int AW   = RF_AW,
  parameter  int DW   = RF_DW,
  localparam int IW   = $clog2(NREQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     stall,
  regfile_write_arbiter_if.slave   wb,
  output logic                     we3,
  output logic [AW-1:0]            wa3,
  output logic [DW-1:0]            wd3,
  output logic [IW-1:0]            grant_id
);
  logic [NREQ-1:0] req_eff;
  logic [NREQ-1:0] grant;
  logic [IW-1:0]   idx;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   ptr_nxt;
  logic            any;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_data;

  // Reset and stall both block every grant.
  assign req_eff = (reset || stall) ? '0 : wb.req_valid;

  rr_priority_pick #(.N(NREQ)) u_pick (
    .req   (req_eff),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (idx),
    .any   (any)
  );

  assign wb.req_ready = grant;
  assign sel_addr = wb.req_addr[int'(idx)*AW +: AW];
  assign sel_data = wb.req_data[int'(idx)*DW +: DW];
  assign ptr_nxt  = (int'(idx) == NREQ - 1) ? '0 : idx + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      we3      <= 1'b0;
      wa3      <= '0;
      wd3      <= '0;
      grant_id <= '0;
      rr_ptr   <= '0;
    end else if (any) begin
      we3      <= (sel_addr != AW'(RF_ZERO_REG));
      wa3      <= sel_addr;
      wd3      <= sel_data;
      grant_id <= idx;
      rr_ptr   <= ptr_nxt;
    end else begin
      we3 <= 1'b0;
    end
  end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with two requesters.
module tb_regfile_write_arbiter;
  import regfile_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic stall = 1'b0;
  logic we3;
  logic [4:0] wa3;
  logic [31:0] wd3;
  logic grant_id;

  wb_req_t r0, r1;
  int checks = 0;
  int passed = 0;

  regfile_write_arbiter_if #(.NREQ(2), .AW(5), .DW(32)) bus ();

  assign bus.req_valid = {r1.valid, r0.valid};
  assign bus.req_addr  = {r1.addr, r0.addr};
  assign bus.req_data  = {r1.data, r0.data};

  regfile_write_arbiter #(.NREQ(2), .AW(5), .DW(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .stall    (stall),
    .wb       (bus),
    .we3      (we3),
    .wa3      (wa3),
    .wd3      (wd3),
    .grant_id (grant_id)
  );

  always #5 clk = ~clk;

  // Requester rule: a pending request keeps addr/data stable.
  logic [1:0]  hold = '0;
  logic [36:0] held [2];
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (hold[i] && bus.req_valid[i])
        assert ({bus.req_addr[i*5 +: 5], bus.req_data[i*32 +: 32]} == held[i])
        else $error("requester %0d changed while pending", i);
      hold[i] <= !reset && bus.req_valid[i] && !bus.req_ready[i];
      held[i] <= {bus.req_addr[i*5 +: 5], bus.req_data[i*32 +: 32]};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    r0 = '{valid: 1'b1, addr: 5'd5, data: 32'h55};
    r1 = '{valid: 1'b1, addr: 5'd6, data: 32'h66};
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 2'b00)
      $display("FAIL reset_ready got %b want 00", bus.req_ready);
    else passed++;
    tick();
    tick();
    checks++;
    if (we3 !== 1'b0) $display("FAIL reset_we3 got %b want 0", we3);
    else passed++;
    checks++;
    if (wa3 !== 5'd0) $display("FAIL reset_wa3 got %0d want 0", wa3);
    else passed++;
    checks++;
    if (wd3 !== 32'd0) $display("FAIL reset_wd3 got %h want 0", wd3);
    else passed++;
    checks++;
    if (grant_id !== 1'b0) $display("FAIL reset_gid got %b want 0", grant_id);
    else passed++;
    checks++;
    if (dut.rr_ptr !== 1'b0) $display("FAIL reset_ptr got %b want 0", dut.rr_ptr);
    else passed++;
    reset = 1'b0;
    r0.valid = 1'b0;
    r1.valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 2'b00)
      $display("FAIL idle_ready got %b want 00", bus.req_ready);
    else passed++;
    tick();
  endtask

  task automatic test_single();
    r1 = '{valid: 1'b1, addr: 5'd18, data: 32'd255};
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 2'b10)
      $display("FAIL single_ready got %b want 10", bus.req_ready);
    else passed++;
    tick();
    r1.valid = 1'b0;
    checks++;
    if ({we3, wa3, wd3, grant_id} !== {1'b1, 5'd18, 32'd255, 1'b1})
      $display("FAIL single_commit got we=%b wa=%0d wd=%0d gid=%b want 1 18 255 1",
               we3, wa3, wd3, grant_id);
    else passed++;
    tick();
    checks++;
    if (we3 !== 1'b0 || wa3 !== 5'd18)
      $display("FAIL single_after got we=%b wa=%0d want we=0 wa=18", we3, wa3);
    else passed++;
  endtask

  task automatic test_contention();
    logic [1:0]  exp_rdy [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    logic [4:0]  exp_wa  [4] = '{5'd18, 5'd19, 5'd18, 5'd19};
    logic [31:0] exp_wd  [4] = '{32'hFF, 32'hFFF, 32'hFF, 32'hFFF};
    r0 = '{valid: 1'b1, addr: 5'd18, data: 32'hFF};
    r1 = '{valid: 1'b1, addr: 5'd19, data: 32'hFFF};
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (bus.req_ready !== exp_rdy[k])
        $display("FAIL cont_ready[%0d] got %b want %b", k, bus.req_ready, exp_rdy[k]);
      else passed++;
      tick();
      checks++;
      if ({we3, wa3, wd3, grant_id} !== {1'b1, exp_wa[k], exp_wd[k], 1'(k % 2)})
        $display("FAIL cont_commit[%0d] got we=%b wa=%0d wd=%h gid=%b want 1 %0d %h %0d",
                 k, we3, wa3, wd3, grant_id, exp_wa[k], exp_wd[k], k % 2);
      else passed++;
    end
    r0.valid = 1'b0;
    r1.valid = 1'b0;
    tick();
  endtask

  task automatic test_x0();
    r0 = '{valid: 1'b1, addr: 5'd0, data: 32'hDEAD};
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 2'b01)
      $display("FAIL x0_ready got %b want 01", bus.req_ready);
    else passed++;
    tick();
    r0.valid = 1'b0;
    checks++;
    if (we3 !== 1'b0) $display("FAIL x0_we3 got %b want 0", we3);
    else passed++;
    checks++;
    if (dut.rr_ptr !== 1'b1) $display("FAIL x0_ptr got %b want 1", dut.rr_ptr);
    else passed++;
    checks++;
    if (wa3 !== 5'd0 || grant_id !== 1'b0)
      $display("FAIL x0_addr got wa=%0d gid=%b want 0 0", wa3, grant_id);
    else passed++;
  endtask

  task automatic test_stall();
    r0 = '{valid: 1'b1, addr: 5'd3, data: 32'h33};
    r1 = '{valid: 1'b1, addr: 5'd4, data: 32'h44};
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (bus.req_ready !== 2'b00)
        $display("FAIL stall_ready[%0d] got %b want 00", k, bus.req_ready);
      else passed++;
      tick();
      checks++;
      if (we3 !== 1'b0) $display("FAIL stall_we3[%0d] got %b want 0", k, we3);
      else passed++;
    end
    stall = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 2'b10)
      $display("FAIL unstall_ready got %b want 10", bus.req_ready);
    else passed++;
    tick();
    r0.valid = 1'b0;
    r1.valid = 1'b0;
    checks++;
    if ({we3, wa3, wd3, grant_id} !== {1'b1, 5'd4, 32'h44, 1'b1})
      $display("FAIL unstall_commit got we=%b wa=%0d wd=%h gid=%b want 1 4 44 1",
               we3, wa3, wd3, grant_id);
    else passed++;
    checks++;
    if (dut.rr_ptr !== 1'b0) $display("FAIL unstall_ptr got %b want 0", dut.rr_ptr);
    else passed++;
    tick();
  endtask

  task automatic test_reset_midop();
    r0 = '{valid: 1'b1, addr: 5'd20, data: 32'h2020};
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 2'b00)
      $display("FAIL midrst_ready got %b want 00", bus.req_ready);
    else passed++;
    tick();
    reset = 1'b0;
    r0.valid = 1'b0;
    checks++;
    if (we3 !== 1'b0 || wa3 !== 5'd0)
      $display("FAIL midrst_commit got we=%b wa=%0d want 0 0", we3, wa3);
    else passed++;
    checks++;
    if (dut.rr_ptr !== 1'b0) $display("FAIL midrst_ptr got %b want 0", dut.rr_ptr);
    else passed++;
    tick();
    checks++;
    if (we3 !== 1'b0) $display("FAIL midrst_after got %b want 0", we3);
    else passed++;
  endtask

  initial begin
    r0 = '0;
    r1 = '0;
    test_reset();
    test_single();
    test_contention();
    test_x0();
    test_stall();
    test_reset_midop();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
